// File: rtl/lvds_rx_pkg.sv
// lvds_rx_pkg: shared types and constants for the LVDS receive phase
// alignment controller (FSM state encoding, phase-step count, fail codes,
// default PLL duty / fine-delay settings).
package lvds_rx_pkg;

  localparam int PSDA_STEPS = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_LOCK_SETTLE,
    ST_SET_PHASE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_EVAL,
    ST_APPLY,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam logic [1:0] FAIL_NONE = 2'd0;
  localparam logic [1:0] FAIL_LOCK = 2'd1;
  localparam logic [1:0] FAIL_EYE  = 2'd2;

  localparam logic [3:0] LVDS_DUTY_DEFAULT = 4'b1000;
  localparam logic [3:0] LVDS_FDLY_DEFAULT = 4'b0000;

endpackage

// File: rtl/lvds_rx_eye_search.sv
// lvds_rx_eye_search: sequential circular longest-run scan over the 16-bit
// per-phase pass map. One index per cycle over 0..31 so runs that wrap past
// phase 15 are seen whole. Result (done pulse) arrives 34 cycles after the
// cycle in which go is seen high.
//   clk, reset   : clock, synchronous active-high reset
//   go           : one-cycle pulse, (re)start a scan of pass_map
//   pass_map     : per-phase pass bits, must be stable during the scan
//   done         : one-cycle pulse, eye_start/eye_len/centre valid
//   eye_start    : first phase of the widest run
//   eye_len      : run length 0..16
//   centre       : phase at the middle of the run
module lvds_rx_eye_search
  import lvds_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [15:0] pass_map,
  output logic        done,
  output logic [3:0]  eye_start,
  output logic [4:0]  eye_len,
  output logic [3:0]  centre
);

  logic [4:0] idx;
  logic       scanning;
  logic       finish;
  logic [4:0] run;
  logic [4:0] best_len;
  logic [3:0] best_end;
  logic [4:0] run_n;
  logic [3:0] es;

  always_comb begin
    run_n = 5'd0;
    if (pass_map[idx[3:0]])
      run_n = (run == 5'd16) ? 5'd16 : run + 5'd1;
    // best_len < 16 whenever this is used, so the 4-bit wrap is exact
    es = best_end - best_len[3:0] + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      scanning  <= 1'b0;
      finish    <= 1'b0;
      run       <= '0;
      best_len  <= '0;
      best_end  <= '0;
      done      <= 1'b0;
      eye_start <= '0;
      eye_len   <= '0;
      centre    <= '0;
    end else begin
      done   <= 1'b0;
      finish <= 1'b0;
      if (go) begin
        scanning <= 1'b1;
        idx      <= '0;
        run      <= '0;
        best_len <= '0;
        best_end <= '0;
      end else if (scanning) begin
        run <= run_n;
        // strict > keeps the earliest of equal-length runs
        if (run_n > best_len) begin
          best_len <= run_n;
          best_end <= idx[3:0];
        end
        idx <= idx + 5'd1;
        if (idx == 5'd31) begin
          scanning <= 1'b0;
          finish   <= 1'b1;
        end
      end else if (finish) begin
        done <= 1'b1;
        if (best_len == 5'd16) begin
          eye_start <= 4'd0;
          eye_len   <= 5'd16;
          centre    <= 4'd8;
        end else begin
          eye_start <= es;
          eye_len   <= best_len;
          centre    <= es + best_len[4:1];
        end
      end
    end
  end

endmodule

// File: rtl/lvds_rx_phase_align.sv
// lvds_rx_phase_align: LVDS receive PLL bring-up and phase alignment.
// Pulses the PLL reset, waits for lock, sweeps all 16 psda steps scoring each
// against the deserializer training-pattern match, then parks psda at the
// centre of the widest (circular) passing eye. Loss of lock after lock was
// seen restarts the whole sequence.
//   clk, reset        : clock, synchronous active-high reset
//   start             : pulse, begin (re)alignment when not busy
//   pll_lock          : async PLL lock, synchronised here
//   word_valid/match  : deserializer word strobe / training-pattern match
//   pll_reset, psda, dutyda, fdly : PLL controls
//   busy, aligned, fail, fail_code : status to link controller
//   eye_start, eye_len, pass_map   : results of the last sweep
module lvds_rx_phase_align
  import lvds_rx_pkg::*;
#(
  parameter int          RESET_CYCLES  = 16,
  parameter int          LOCK_TIMEOUT  = 65536,
  parameter int          LOCK_WAIT     = 1024,
  parameter int          SETTLE_CYCLES = 256,
  parameter int          SAMPLE_CYCLES = 1024,
  parameter int          MIN_EYE       = 3,
  parameter logic [3:0]  DUTY_DEFAULT  = LVDS_DUTY_DEFAULT,
  parameter logic [3:0]  FDLY_DEFAULT  = LVDS_FDLY_DEFAULT
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pll_lock,
  input  logic        word_valid,
  input  logic        word_match,
  output logic        pll_reset,
  output logic [3:0]  psda,
  output logic [3:0]  dutyda,
  output logic [3:0]  fdly,
  output logic        busy,
  output logic        aligned,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [3:0]  eye_start,
  output logic [4:0]  eye_len,
  output logic [15:0] pass_map
);

  localparam logic [31:0] RST_LAST    = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] TMO_LAST    = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] LWAIT_LAST  = 32'(LOCK_WAIT - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] SAMPLE_LAST = 32'(SAMPLE_CYCLES - 1);
  localparam logic [4:0]  MIN_EYE_W   = 5'(MIN_EYE);

  state_e      state;
  logic [31:0] cnt;
  logic [3:0]  p;
  logic        lock_meta, lock_s;
  logic        seen, bad;
  logic        eval_go;
  logic [3:0]  centre_q;
  logic        es_done;
  logic [3:0]  es_start, es_centre;
  logic [4:0]  es_len;
  logic        lock_lost;
  logic        pass_now;

  assign dutyda = DUTY_DEFAULT;
  assign fdly   = FDLY_DEFAULT;

  // lock only matters once it has been seen: LOCK_SETTLE through APPLY, DONE
  assign lock_lost = !lock_s &&
                     (state inside {ST_LOCK_SETTLE, ST_SET_PHASE, ST_SETTLE,
                                    ST_SAMPLE, ST_NEXT, ST_EVAL, ST_APPLY,
                                    ST_DONE});

  // verdict including the final sample cycle's word
  assign pass_now = (seen | word_valid) & ~(bad | (word_valid & ~word_match));

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  lvds_rx_eye_search u_eye (
    .clk       (clk),
    .reset     (reset),
    .go        (eval_go),
    .pass_map  (pass_map),
    .done      (es_done),
    .eye_start (es_start),
    .eye_len   (es_len),
    .centre    (es_centre)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      p         <= '0;
      seen      <= 1'b0;
      bad       <= 1'b0;
      eval_go   <= 1'b0;
      centre_q  <= '0;
      pll_reset <= 1'b1;
      psda      <= '0;
      busy      <= 1'b0;
      aligned   <= 1'b0;
      fail      <= 1'b0;
      fail_code <= FAIL_NONE;
      eye_start <= '0;
      eye_len   <= '0;
      pass_map  <= '0;
    end else begin
      eval_go <= 1'b0;
      cnt     <= cnt + 32'd1;
      if (lock_lost) begin
        state     <= ST_PLL_RST;
        cnt       <= '0;
        pll_reset <= 1'b1;
        psda      <= '0;
        busy      <= 1'b1;
        aligned   <= 1'b0;
        pass_map  <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
              state     <= ST_PLL_RST;
              cnt       <= '0;
              pll_reset <= 1'b1;
              psda      <= '0;
              busy      <= 1'b1;
              aligned   <= 1'b0;
              fail      <= 1'b0;
              fail_code <= FAIL_NONE;
              pass_map  <= '0;
            end
          end
          ST_PLL_RST: begin
            if (cnt == RST_LAST) begin
              state     <= ST_WAIT_LOCK;
              cnt       <= '0;
              pll_reset <= 1'b0;
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_s) begin
              state <= ST_LOCK_SETTLE;
              cnt   <= '0;
            end else if (cnt == TMO_LAST) begin
              state     <= ST_FAIL;
              fail      <= 1'b1;
              fail_code <= FAIL_LOCK;
              busy      <= 1'b0;
              pll_reset <= 1'b0;
              psda      <= '0;
            end
          end
          ST_LOCK_SETTLE: begin
            if (cnt == LWAIT_LAST) begin
              state <= ST_SET_PHASE;
              p     <= '0;
            end
          end
          ST_SET_PHASE: begin
            psda  <= p;
            state <= ST_SETTLE;
            cnt   <= '0;
          end
          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state <= ST_SAMPLE;
              cnt   <= '0;
              seen  <= 1'b0;
              bad   <= 1'b0;
            end
          end
          ST_SAMPLE: begin
            if (word_valid) begin
              seen <= 1'b1;
              if (!word_match) bad <= 1'b1;
            end
            if (cnt == SAMPLE_LAST) begin
              pass_map[p] <= pass_now;
              state       <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (p == 4'(PSDA_STEPS - 1)) begin
              state   <= ST_EVAL;
              eval_go <= 1'b1;
            end else begin
              p     <= p + 4'd1;
              state <= ST_SET_PHASE;
            end
          end
          ST_EVAL: begin
            if (es_done) begin
              eye_start <= es_start;
              eye_len   <= es_len;
              centre_q  <= es_centre;
              state     <= ST_APPLY;
              cnt       <= '0;
            end
          end
          ST_APPLY: begin
            if (eye_len < MIN_EYE_W) begin
              state     <= ST_FAIL;
              fail      <= 1'b1;
              fail_code <= FAIL_EYE;
              busy      <= 1'b0;
              pll_reset <= 1'b0;
              psda      <= '0;
            end else begin
              psda <= centre_q;
              if (cnt == SETTLE_LAST) begin
                state   <= ST_DONE;
                aligned <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_rx_phase_align.sv
// tb_lvds_rx_phase_align: directed bench. A small PLL model raises lock 10
// cycles after pll_reset falls (unless held low); a deserializer model
// strobes word_valid every other cycle and drives word_match from per-phase
// masks indexed by psda. Expected values are hand-computed for
// RESET_CYCLES=4, LOCK_WAIT=8, SETTLE_CYCLES=4, SAMPLE_CYCLES=16, MIN_EYE=3.
module tb_lvds_rx_phase_align;

  logic        clk, reset, start, pll_lock, word_valid, word_match;
  logic        pll_reset, busy, aligned, fail;
  logic [3:0]  psda, dutyda, fdly, eye_start;
  logic [4:0]  eye_len;
  logic [1:0]  fail_code;
  logic [15:0] pass_map;

  logic [15:0] match_mask, valid_mask;
  logic        hold_low, tick;
  int          lock_cnt;
  int          total, bad;

  // start edge to aligned: 4 reset + 10 lock + 2 sync + 8 settle + 16*22
  // sweep + 34 eval + 1 + 4 apply settle
  localparam int CYC_ALIGN = 415;
  localparam int CYC_EYEFAIL = 412;
  localparam int CYC_LOCKTMO = 65540;

  lvds_rx_phase_align #(
    .RESET_CYCLES (4),
    .LOCK_WAIT    (8),
    .SETTLE_CYCLES(4),
    .SAMPLE_CYCLES(16),
    .MIN_EYE      (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pll_lock   (pll_lock),
    .word_valid (word_valid),
    .word_match (word_match),
    .pll_reset  (pll_reset),
    .psda       (psda),
    .dutyda     (dutyda),
    .fdly       (fdly),
    .busy       (busy),
    .aligned    (aligned),
    .fail       (fail),
    .fail_code  (fail_code),
    .eye_start  (eye_start),
    .eye_len    (eye_len),
    .pass_map   (pass_map)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick = ~tick;
    if (pll_reset || hold_low) begin
      lock_cnt = 0;
      pll_lock = 1'b0;
    end else begin
      if (lock_cnt < 10) lock_cnt++;
      if (lock_cnt >= 10) pll_lock = 1'b1;
    end
    word_valid = valid_mask[psda] & tick;
    word_match = tick & match_mask[psda];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_seq(input bit poke, input int limit, output int cyc, output int rc);
    int n;
    n  = 0;
    rc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_on", 32'(busy), 32'd1);
    while (!(aligned || fail) && n < limit) begin
      if (pll_reset) rc++;
      start = poke && (n == 50 || n == 200);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= limit) chk("seq_timeout", 32'd0, 32'd1);
    cyc = n;
  endtask

  task automatic sweep_ok(input string tag, input logic [15:0] vmask, input logic [15:0] mmask,
                          input logic [3:0] es, input logic [4:0] el, input logic [3:0] ps);
    int cyc, rc;
    valid_mask = vmask;
    match_mask = mmask;
    run_seq(1'b0, 2000, cyc, rc);
    $display("sweep %s", tag);
    chk("cycles", 32'(cyc), 32'(CYC_ALIGN));
    chk("aligned", 32'(aligned), 32'd1);
    chk("fail", 32'(fail), 32'd0);
    chk("pass_map", 32'(pass_map), 32'(mmask & vmask));
    chk("eye_start", 32'(eye_start), 32'(es));
    chk("eye_len", 32'(eye_len), 32'(el));
    chk("psda", 32'(psda), 32'(ps));
  endtask

  initial begin
    int cyc, rc, n;
    clk = 0; reset = 1; start = 0; hold_low = 0; tick = 0;
    pll_lock = 0; word_valid = 0; word_match = 0; lock_cnt = 0;
    match_mask = '0; valid_mask = '0;
    total = 0; bad = 0;

    repeat (3) @(negedge clk);
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_psda", 32'(psda), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_status", {aligned, fail, fail_code}, 4'd0);
    chk("rst_eye", {eye_start, eye_len, pass_map}, 25'd0);
    chk("dutyda", 32'(dutyda), 32'h8);
    chk("fdly", 32'(fdly), 32'h0);
    reset = 0;
    repeat (5) @(negedge clk);
    chk("idle_pll_reset", 32'(pll_reset), 32'd1);

    // eye at 5..9, also checks reset pulse width
    valid_mask = 16'hFFFF;
    match_mask = 16'h03E0;
    run_seq(1'b0, 2000, cyc, rc);
    chk("rst_width", 32'(rc), 32'd4);
    chk("cycles", 32'(cyc), 32'(CYC_ALIGN));
    chk("aligned", 32'(aligned), 32'd1);
    chk("fail", 32'(fail), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("pass_map", 32'(pass_map), 32'h03E0);
    chk("eye_start", 32'(eye_start), 32'd5);
    chk("eye_len", 32'(eye_len), 32'd5);
    chk("psda", 32'(psda), 32'd7);

    sweep_ok("wrap",   16'hFFFF, 16'hC003, 4'd14, 5'd4,  4'd0);
    sweep_ok("tie",    16'hFFFF, 16'h1C1C, 4'd2,  5'd3,  4'd3);
    sweep_ok("all",    16'hFFFF, 16'hFFFF, 4'd0,  5'd16, 4'd8);
    sweep_ok("novld6", 16'hFFBF, 16'hFFFF, 4'd7,  5'd15, 4'd14);
    chk("pm6", 32'(pass_map[6]), 32'd0);

    // nothing matches: eye below minimum
    valid_mask = 16'hFFFF;
    match_mask = 16'h0000;
    run_seq(1'b0, 2000, cyc, rc);
    chk("eyefail_cycles", 32'(cyc), 32'(CYC_EYEFAIL));
    chk("eyefail_fail", 32'(fail), 32'd1);
    chk("eyefail_code", 32'(fail_code), 32'd2);
    chk("eyefail_psda", 32'(psda), 32'd0);
    chk("eyefail_aligned", 32'(aligned), 32'd0);
    chk("eyefail_busy", 32'(busy), 32'd0);
    chk("eyefail_pll_reset", 32'(pll_reset), 32'd0);

    // extra starts while busy must not disturb the sequence
    match_mask = 16'h03E0;
    run_seq(1'b1, 2000, cyc, rc);
    chk("poke_cycles", 32'(cyc), 32'(CYC_ALIGN));
    chk("poke_psda", 32'(psda), 32'd7);
    chk("poke_aligned", 32'(aligned), 32'd1);

    // lock loss while aligned
    @(posedge clk);
    #1 hold_low = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("ll_aligned", 32'(aligned), 32'd0);
    chk("ll_pll_reset", 32'(pll_reset), 32'd1);
    chk("ll_busy", 32'(busy), 32'd1);
    chk("ll_fail", 32'(fail), 32'd0);
    chk("ll_pass_map", 32'(pass_map), 32'd0);
    hold_low = 1'b0;
    n = 0;
    while (pll_reset && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("ll_rst_width", 32'(n), 32'd4);
    n = 0;
    while (!aligned && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("ll_realigned", 32'(aligned), 32'd1);
    chk("ll_psda", 32'(psda), 32'd7);
    chk("ll_pass_map2", 32'(pass_map), 32'h03E0);

    // reset mid-sweep
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_pll_reset", 32'(pll_reset), 32'd1);
    chk("mid_psda", 32'(psda), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_status", {aligned, fail, fail_code}, 4'd0);
    chk("mid_eye", {eye_start, eye_len, pass_map}, 25'd0);
    repeat (5) @(negedge clk);

    // lock never arrives
    hold_low = 1'b1;
    run_seq(1'b0, 70000, cyc, rc);
    chk("tmo_cycles", 32'(cyc), 32'(CYC_LOCKTMO));
    chk("tmo_fail", 32'(fail), 32'd1);
    chk("tmo_code", 32'(fail_code), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_aligned", 32'(aligned), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lvds_rx_phase_align.md
Name: lvds_rx_phase_align

Overview:
- Sequences the LVDS receive PLL after power-up and after any loss of lock.
- Owns the PLL's reset and its dynamic phase (psda), duty (dutyda) and fine-delay (fdly) controls.
- Sweeps all 16 psda phase steps, scores each step against the deserializer's training-pattern match, finds the widest passing eye (circular), and parks psda at the eye centre.
- Sits between the PLL wrapper and the 7:1 deserializer/word-alignment logic; reports busy/aligned/fail to the link controller.

Parameters:
- RESET_CYCLES, 16: pll_reset pulse width in clk cycles.
- LOCK_TIMEOUT, 65536: maximum cycles waiting for pll_lock before failing.
- LOCK_WAIT, 1024: cycles after lock before the sweep begins.
- SETTLE_CYCLES, 256: cycles after each psda change before scoring.
- SAMPLE_CYCLES, 1024: scoring window per phase, in cycles.
- MIN_EYE, 3: minimum passing-run length accepted.
- DUTY_DEFAULT, 4'b1000: constant dutyda value.
- FDLY_DEFAULT, 4'b0000: constant fdly value.

Ports:
- clk  in  1  controller clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin (re)alignment
- pll_lock  in  1  PLL lock, asynchronous; 2-FF synchronised internally
- word_valid  in  1  deserialized-word strobe (clk domain)
- word_match  in  1  word equals training pattern; qualified by word_valid
- pll_reset  out  1  PLL reset
- psda  out  4  PLL dynamic phase select
- dutyda  out  4  PLL duty select, = DUTY_DEFAULT
- fdly  out  4  PLL fine delay, = FDLY_DEFAULT
- busy  out  1  sequence in progress
- aligned  out  1  psda parked at eye centre, lock held
- fail  out  1  sequence failed
- fail_code  out  2  0 none, 1 lock timeout, 2 eye below MIN_EYE
- eye_start  out  4  first phase of the chosen eye
- eye_len  out  5  chosen eye length, 0..16
- pass_map  out  16  per-phase pass bits from the last sweep

Behaviour:
- Reset values:
  - pll_reset=1, psda=0, busy=0, aligned=0, fail=0, fail_code=0, eye_start=0, eye_len=0, pass_map=0, state IDLE.
  - The PLL is held in reset until the first start.
- States: IDLE, PLL_RST, WAIT_LOCK, LOCK_SETTLE, SET_PHASE, SETTLE, SAMPLE, NEXT, EVAL, APPLY, DONE, FAIL.
- IDLE/DONE/FAIL + start → PLL_RST. On entry: clear aligned/fail/fail_code/pass_map; busy=1 from the next cycle.
- start while busy=1 is ignored.
- PLL_RST: pll_reset=1 for exactly RESET_CYCLES cycles, psda=0, then → WAIT_LOCK with pll_reset=0.
- WAIT_LOCK: on synced lock=1 → LOCK_SETTLE. After LOCK_TIMEOUT cycles without lock → FAIL, fail_code=1.
- LOCK_SETTLE: wait LOCK_WAIT cycles, phase index p=0 → SET_PHASE.
- SET_PHASE: psda<=p (one cycle) → SETTLE for SETTLE_CYCLES → SAMPLE.
- SAMPLE: SAMPLE_CYCLES cycles.
  - Phase passes iff at least one word_valid was seen and no word_valid had word_match=0.
  - pass_map[p]<=result.
- NEXT: p==15 → EVAL, else p+1 → SET_PHASE.
- EVAL (handled by the lvds_rx_eye_search sub-block):
  - Scan indices 0..31, one per cycle, bit = pass_map[i mod 16].
  - Run counter saturates at 16; strict > update of best, so the earliest maximal run wins on ties.
  - If pass_map==16'hFFFF: eye_start=0, eye_len=16, centre=8.
  - Otherwise: eye_start=(best_end−best_len+1) mod 16, centre=(eye_start+floor(eye_len/2)) mod 16.
  - Fixed latency 34 cycles from EVAL entry to result.
- APPLY:
  - eye_len<MIN_EYE → FAIL, fail_code=2, psda=0.
  - Otherwise psda<=centre, wait SETTLE_CYCLES → DONE.
- DONE: aligned=1, busy=0.
- FAIL: fail=1, busy=0, pll_reset=0, psda=0.
- Lock loss:
  - In LOCK_SETTLE..APPLY or DONE, synced lock=0 → PLL_RST automatically.
  - aligned drops in the same cycle the state leaves DONE.
  - pass_map is cleared; fail is not set.
- reset mid-sequence: all outputs return to reset values next edge; the sweep is abandoned.
- word_valid/word_match are ignored outside SAMPLE.

Decomposition:
- Package lvds_rx_pkg:
  - state enum
  - PSDA_STEPS=16
  - fail-code constants
  - DUTY_DEFAULT/FDLY_DEFAULT defaults
- Sub-module lvds_rx_eye_search:
  - Inputs: clk, reset, go, pass_map[15:0].
  - Outputs: done, eye_start[3:0], eye_len[4:0], centre[3:0].
  - Contains the sequential circular longest-run scan.

Test Plan (RESET_CYCLES=4, LOCK_WAIT=8, SETTLE_CYCLES=4, SAMPLE_CYCLES=16, MIN_EYE=3):
- Lock 10 cycles after reset release; match only at phases 5..9 → pll_reset high 4 cycles, pass_map=16'h03E0, eye_start=5, eye_len=5, psda=7, aligned=1, fail=0.
- Wrap-around eye, match at phases 14,15,0,1 → pass_map=16'hC003, eye_start=14, eye_len=4, psda=0, aligned=1.
- Two equal eyes at 2..4 and 10..12 → eye_start=2, eye_len=3, psda=3. All phases pass → eye_start=0, eye_len=16, psda=8.
- Phase 6 has word_valid never asserted, all others match → pass_map[6]=0. All phases mismatch → fail=1, fail_code=2, psda=0, aligned=0.
- pll_lock held 0 → fail=1, fail_code=1 after 65536 cycles in WAIT_LOCK. start pulsed while busy → no effect on state or cycle count.
- In DONE, drop pll_lock → aligned=0 within 3 cycles, pll_reset pulses 4 cycles, full re-sweep, aligned=1 again with the same psda.
